// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI receiver: opcodes, FSM states, widths.
package oled_pkg;

   localparam int COL_W  = 7;
   localparam int PAGE_W = 3;

   // Opcodes the command decoder acts on
   localparam logic [7:0] CMD_SET_COL     = 8'h21;
   localparam logic [7:0] CMD_SET_PAGE    = 8'h22;
   localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
   localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;

   // Single-argument commands whose argument is swallowed without effect
   localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
   localparam logic [7:0] CMD_CONTRAST    = 8'h81;
   localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
   localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
   localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
   localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
   localparam logic [7:0] CMD_COM_PINS    = 8'hDA;
   localparam logic [7:0] CMD_VCOMH       = 8'hDB;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COL_START,
      ST_COL_END,
      ST_PAGE_START,
      ST_PAGE_END,
      ST_SKIP1
   } cmd_state_t;

   // True for commands that carry one argument byte we do not interpret
   function automatic logic is_skip_cmd(input logic [7:0] op);
      return (op == CMD_ADDR_MODE)   || (op == CMD_CONTRAST)    ||
             (op == CMD_CHARGE_PUMP) || (op == CMD_MUX_RATIO)   ||
             (op == CMD_DISP_OFFSET) || (op == CMD_CLK_DIV)     ||
             (op == CMD_PRECHARGE)   || (op == CMD_COM_PINS)    ||
             (op == CMD_VCOMH);
   endfunction

endpackage

// File: rtl/oled_spi_receiver_if.sv
// SPI pin bundle between an OLED host (master) and the byte receiver (slave).
interface oled_spi_receiver_if;
   logic csn;
   logic dc;
   logic sclk;
   logic mosi;

   modport master (output csn, output dc, output sclk, output mosi);
   modport slave  (input csn, input dc, input sclk, input mosi);
endinterface

// File: rtl/oled_spi_byte_rx.sv
// Pin synchronizers, SCLK rising-edge detection and 8-bit shift/bit counter.
// Offers a single-cycle strobe with the completed byte (combinational, aligned
// to the 8th detected edge) and a registered truncated-byte pulse.
module oled_spi_byte_rx
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   oled_spi_receiver_if.slave    bus,
   output logic                  rx_strobe,
   output logic [7:0]            rx_data,
   output logic                  rx_dc,
   output logic                  frame_err
);

   // Packed as {mosi, sclk, dc, csn}; idle levels keep csn high, rest low
   localparam logic [3:0] SYNC_IDLE = 4'b0001;

   logic [SYNC_STAGES-1:0][3:0] sync_reg;
   logic [3:0]                  pin_vec;
   logic                        csn_s, dc_s, sclk_s, mosi_s;
   logic                        sclk_prev_reg;
   logic                        csn_prev_reg;
   logic [2:0]                  cnt_reg;
   logic [6:0]                  shift_reg;
   logic                        err_reg;
   logic                        sclk_rise;

   assign pin_vec = {bus.mosi, bus.sclk, bus.dc, bus.csn};
   assign csn_s   = sync_reg[SYNC_STAGES-1][0];
   assign dc_s    = sync_reg[SYNC_STAGES-1][1];
   assign sclk_s  = sync_reg[SYNC_STAGES-1][2];
   assign mosi_s  = sync_reg[SYNC_STAGES-1][3];

   // Edges are only meaningful while the chip is selected
   assign sclk_rise = sclk_s & ~sclk_prev_reg & ~csn_s;

   assign rx_strobe = sclk_rise && (cnt_reg == 3'd7);
   assign rx_data   = {shift_reg, mosi_s};
   assign rx_dc     = dc_s;
   assign frame_err = err_reg;

   // Synchronizer chain, edge history, bit shifting and truncation detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_reg      <= {SYNC_STAGES{SYNC_IDLE}};
         sclk_prev_reg <= 1'b0;
         csn_prev_reg  <= 1'b1;
         cnt_reg       <= 3'd0;
         shift_reg     <= 7'd0;
         err_reg       <= 1'b0;
      end else begin
         sync_reg      <= {sync_reg[SYNC_STAGES-2:0], pin_vec};
         sclk_prev_reg <= sclk_s;
         csn_prev_reg  <= csn_s;
         // Deselect in the middle of a byte: the partial bits are dropped
         err_reg       <= csn_s & ~csn_prev_reg & (cnt_reg != 3'd0);
         if (csn_s) begin
            cnt_reg <= 3'd0;
         end else if (sclk_rise) begin
            shift_reg <= {shift_reg[5:0], mosi_s};
            cnt_reg   <= cnt_reg + 3'd1;
         end
      end
   end

endmodule

// File: rtl/oled_spi_receiver.sv
// OLED controller front end: receives SPI bytes, decodes the command subset
// that shapes the GDDRAM write window, and turns data bytes into pixel writes
// with a horizontally auto-incrementing pointer.
module oled_spi_receiver
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_ref_in,
   input  logic              reset_in,
   input  logic              oled_csn_in,
   input  logic              oled_dc_in,
   input  logic              oled_clk_in,
   input  logic              oled_mosi_in,
   output logic              byte_valid_out,
   output logic [7:0]        byte_out,
   output logic              byte_dc_out,
   output logic              pixel_we_out,
   output logic [COL_W-1:0]  pixel_col_out,
   output logic [PAGE_W-1:0] pixel_page_out,
   output logic [7:0]        pixel_data_out,
   output logic              display_on_out,
   output logic              frame_done_out,
   output logic              framing_err_out
);

   oled_spi_receiver_if pins ();

   assign pins.csn  = oled_csn_in;
   assign pins.dc   = oled_dc_in;
   assign pins.sclk = oled_clk_in;
   assign pins.mosi = oled_mosi_in;

   logic       rx_strobe;
   logic [7:0] rx_data;
   logic       rx_dc;
   logic       frame_err;

   oled_spi_byte_rx #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_byte_rx (
      .clk       (clk_ref_in),
      .rst       (reset_in),
      .bus       (pins.slave),
      .rx_strobe (rx_strobe),
      .rx_data   (rx_data),
      .rx_dc     (rx_dc),
      .frame_err (frame_err)
   );

   cmd_state_t        state_reg;
   logic              display_on_reg;
   logic [COL_W-1:0]  col_start_reg, col_end_reg, col_ptr_reg;
   logic [PAGE_W-1:0] page_start_reg, page_end_reg, page_ptr_reg;

   logic              byte_valid_reg;
   logic [7:0]        byte_reg;
   logic              byte_dc_reg;
   logic              pix_we_reg;
   logic [COL_W-1:0]  pix_col_reg;
   logic [PAGE_W-1:0] pix_page_reg;
   logic [7:0]        pix_data_reg;
   logic              frame_done_reg;

   logic              at_col_end;
   logic              at_page_end;

   assign at_col_end  = (col_ptr_reg == col_end_reg);
   assign at_page_end = (page_ptr_reg == page_end_reg);

   // Command FSM, write window and write pointer (pointer reloads from commands
   // and advances on data, so both live in this one block)
   always_ff @(posedge clk_ref_in) begin
      if (reset_in) begin
         state_reg      <= ST_IDLE;
         display_on_reg <= 1'b0;
         col_start_reg  <= '0;
         col_end_reg    <= '1;
         page_start_reg <= '0;
         page_end_reg   <= '1;
         col_ptr_reg    <= '0;
         page_ptr_reg   <= '0;
      end else if (rx_strobe) begin
         if (rx_dc) begin
            // Wrapping arithmetic handles start > end windows for free
            if (!at_col_end) begin
               col_ptr_reg <= col_ptr_reg + 1'b1;
            end else begin
               col_ptr_reg  <= col_start_reg;
               page_ptr_reg <= at_page_end ? page_start_reg : page_ptr_reg + 1'b1;
            end
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (rx_data == CMD_SET_COL)
                     state_reg <= ST_COL_START;
                  else if (rx_data == CMD_SET_PAGE)
                     state_reg <= ST_PAGE_START;
                  else if (rx_data == CMD_DISPLAY_OFF)
                     display_on_reg <= 1'b0;
                  else if (rx_data == CMD_DISPLAY_ON)
                     display_on_reg <= 1'b1;
                  else if (is_skip_cmd(rx_data))
                     state_reg <= ST_SKIP1;
               end
               ST_COL_START: begin
                  col_start_reg <= rx_data[COL_W-1:0];
                  col_ptr_reg   <= rx_data[COL_W-1:0];
                  state_reg     <= ST_COL_END;
               end
               ST_COL_END: begin
                  col_end_reg <= rx_data[COL_W-1:0];
                  col_ptr_reg <= col_start_reg;
                  state_reg   <= ST_IDLE;
               end
               ST_PAGE_START: begin
                  page_start_reg <= rx_data[PAGE_W-1:0];
                  page_ptr_reg   <= rx_data[PAGE_W-1:0];
                  state_reg      <= ST_PAGE_END;
               end
               ST_PAGE_END: begin
                  page_end_reg <= rx_data[PAGE_W-1:0];
                  page_ptr_reg <= page_start_reg;
                  state_reg    <= ST_IDLE;
               end
               ST_SKIP1: state_reg <= ST_IDLE;
               default:  state_reg <= ST_IDLE;
            endcase
         end
      end
   end

   // Registered byte and pixel outputs, all aligned to the cycle after the 8th edge
   always_ff @(posedge clk_ref_in) begin
      if (reset_in) begin
         byte_valid_reg <= 1'b0;
         byte_reg       <= 8'd0;
         byte_dc_reg    <= 1'b0;
         pix_we_reg     <= 1'b0;
         pix_col_reg    <= '0;
         pix_page_reg   <= '0;
         pix_data_reg   <= 8'd0;
         frame_done_reg <= 1'b0;
      end else begin
         byte_valid_reg <= rx_strobe;
         pix_we_reg     <= rx_strobe & rx_dc;
         frame_done_reg <= rx_strobe & rx_dc & at_col_end & at_page_end;
         if (rx_strobe) begin
            byte_reg    <= rx_data;
            byte_dc_reg <= rx_dc;
         end
         if (rx_strobe && rx_dc) begin
            pix_col_reg  <= col_ptr_reg;
            pix_page_reg <= page_ptr_reg;
            pix_data_reg <= rx_data;
         end
      end
   end

   assign byte_valid_out  = byte_valid_reg;
   assign byte_out        = byte_reg;
   assign byte_dc_out     = byte_dc_reg;
   assign pixel_we_out    = pix_we_reg;
   assign pixel_col_out   = pix_col_reg;
   assign pixel_page_out  = pix_page_reg;
   assign pixel_data_out  = pix_data_reg;
   assign display_on_out  = display_on_reg;
   assign frame_done_out  = frame_done_reg;
   assign framing_err_out = frame_err;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: SPI byte stimulus, pulse monitor,
// hand-computed expectations.
module tb_oled_spi_receiver;

   logic       clk;
   logic       reset_in;
   logic       byte_valid_out;
   logic [7:0] byte_out;
   logic       byte_dc_out;
   logic       pixel_we_out;
   logic [6:0] pixel_col_out;
   logic [2:0] pixel_page_out;
   logic [7:0] pixel_data_out;
   logic       display_on_out;
   logic       frame_done_out;
   logic       framing_err_out;

   oled_spi_receiver_if spi ();

   oled_spi_receiver #(.SYNC_STAGES(2)) dut (
      .clk_ref_in      (clk),
      .reset_in        (reset_in),
      .oled_csn_in     (spi.csn),
      .oled_dc_in      (spi.dc),
      .oled_clk_in     (spi.sclk),
      .oled_mosi_in    (spi.mosi),
      .byte_valid_out  (byte_valid_out),
      .byte_out        (byte_out),
      .byte_dc_out     (byte_dc_out),
      .pixel_we_out    (pixel_we_out),
      .pixel_col_out   (pixel_col_out),
      .pixel_page_out  (pixel_page_out),
      .pixel_data_out  (pixel_data_out),
      .display_on_out  (display_on_out),
      .frame_done_out  (frame_done_out),
      .framing_err_out (framing_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Pulse monitor: pixel record is {frame_done, page, col, data}
   int          n_valid = 0;
   int          n_pix   = 0;
   int          n_err   = 0;
   int          n_frame = 0;
   logic [18:0] pix_q[$];

   always @(negedge clk) begin
      if (byte_valid_out) n_valid++;
      if (framing_err_out) n_err++;
      if (frame_done_out) n_frame++;
      if (pixel_we_out) begin
         n_pix++;
         pix_q.push_back({frame_done_out, pixel_page_out, pixel_col_out, pixel_data_out});
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Clock nbits of b (MSB first) with csn low; SCLK period is 6 system clocks
   task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
      spi.csn = 1'b0;
      spi.dc  = dc;
      #30;
      for (int i = 0; i < nbits; i++) begin
         spi.mosi = b[7-i];
         #30 spi.sclk = 1'b1;
         #30 spi.sclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic dc, input logic [7:0] b);
      send_bits(dc, b, 8);
      #30 spi.csn = 1'b1;
      repeat (8) @(negedge clk);
      $display("tx dc=%0d byte=0x%02h valid=%0d pix=%0d disp=%0d", dc, b, n_valid, n_pix, display_on_out);
   endtask

   task automatic chk_pix(input string tag, input int idx, input int col, input int page,
                          input int data, input int fd);
      logic [18:0] r;
      r = (idx < pix_q.size()) ? pix_q[idx] : 19'h7FFFF;
      chk({tag, ".col"},  32'(r[14:8]), 32'(col));
      chk({tag, ".page"}, 32'(r[17:15]), 32'(page));
      chk({tag, ".data"}, 32'(r[7:0]),  32'(data));
      chk({tag, ".fd"},   32'(r[18]),   32'(fd));
   endtask

   int v0, e0, f0;

   initial begin
      reset_in = 1'b1;
      spi.csn  = 1'b1;
      spi.dc   = 1'b0;
      spi.sclk = 1'b0;
      spi.mosi = 1'b0;
      repeat (4) @(negedge clk);
      reset_in = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst.byte",  32'(byte_out), 32'h0);
      chk("rst.disp",  32'(display_on_out), 32'h0);
      chk("rst.col",   32'(pixel_col_out), 32'h0);
      chk("rst.valid", 32'(byte_valid_out), 32'h0);

      // Command byte 0xA5: one valid, no pixel write
      send_byte(1'b0, 8'hA5);
      chk("a5.nvalid", 32'(n_valid), 32'd1);
      chk("a5.byte",   32'(byte_out), 32'hA5);
      chk("a5.dc",     32'(byte_dc_out), 32'h0);
      chk("a5.npix",   32'(n_pix), 32'd0);

      // Window cols 2..3, pages 6..7 and four data bytes
      send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h02); send_byte(1'b0, 8'h03);
      send_byte(1'b0, 8'h22); send_byte(1'b0, 8'h06); send_byte(1'b0, 8'h07);
      pix_q.delete();
      f0 = n_frame;
      for (int i = 0; i < 4; i++) send_byte(1'b1, 8'(8'h11 + i));
      chk("win.npix", 32'(pix_q.size()), 32'd4);
      chk_pix("win0", 0, 2, 6, 8'h11, 0);
      chk_pix("win1", 1, 3, 6, 8'h12, 0);
      chk_pix("win2", 2, 2, 7, 8'h13, 0);
      chk_pix("win3", 3, 3, 7, 8'h14, 1);
      chk("win.nframe", 32'(n_frame - f0), 32'd1);
      chk("win.bytedc", 32'(byte_dc_out), 32'h1);

      // Display on/off
      send_byte(1'b0, 8'hAF);
      chk("disp.on",  32'(display_on_out), 32'h1);
      send_byte(1'b0, 8'hAE);
      chk("disp.off", 32'(display_on_out), 32'h0);

      // 0xAF as contrast argument has no effect; next 0xAF does
      send_byte(1'b0, 8'h81);
      send_byte(1'b0, 8'hAF);
      chk("skip.disp", 32'(display_on_out), 32'h0);
      send_byte(1'b0, 8'hAF);
      chk("skip.disp2", 32'(display_on_out), 32'h1);

      // Truncated byte then a clean 0x3C
      v0 = n_valid; e0 = n_err;
      send_bits(1'b0, 8'hF0, 5);
      #30 spi.csn = 1'b1;
      repeat (8) @(negedge clk);
      $display("tx partial 5 bits err=%0d", n_err - e0);
      chk("trunc.nerr",   32'(n_err - e0), 32'd1);
      chk("trunc.nvalid", 32'(n_valid - v0), 32'd0);
      send_byte(1'b0, 8'h3C);
      chk("trunc.byte",   32'(byte_out), 32'h3C);
      chk("trunc.nvalid2", 32'(n_valid - v0), 32'd1);

      // Data write (pointer is back at (2,6)), then reset mid-byte
      pix_q.delete();
      send_byte(1'b1, 8'h55);
      chk_pix("pre", 0, 2, 6, 8'h55, 0);
      send_bits(1'b1, 8'hFF, 4);
      @(negedge clk);
      reset_in = 1'b1;
      repeat (3) @(negedge clk);
      reset_in = 1'b0;
      @(negedge clk);
      $display("tx reset after 4 bits");
      chk("rrst.byte", 32'(byte_out), 32'h0);
      chk("rrst.bdc",  32'(byte_dc_out), 32'h0);
      chk("rrst.col",  32'(pixel_col_out), 32'h0);
      chk("rrst.page", 32'(pixel_page_out), 32'h0);
      chk("rrst.data", 32'(pixel_data_out), 32'h0);
      chk("rrst.disp", 32'(display_on_out), 32'h0);
      e0 = n_err;
      spi.csn = 1'b1;
      repeat (8) @(negedge clk);
      chk("rrst.nerr", 32'(n_err - e0), 32'd0);

      // Pointer and full window restored by reset
      pix_q.delete();
      send_byte(1'b1, 8'h77);
      send_byte(1'b1, 8'h78);
      chk_pix("post0", 0, 0, 0, 8'h77, 0);
      chk_pix("post1", 1, 1, 0, 8'h78, 0);

      // Wrapped column window 127..0
      send_byte(1'b0, 8'h21); send_byte(1'b0, 8'h7F); send_byte(1'b0, 8'h00);
      pix_q.delete();
      send_byte(1'b1, 8'h90); send_byte(1'b1, 8'h91); send_byte(1'b1, 8'h92);
      chk("wrap.npix", 32'(pix_q.size()), 32'd3);
      chk_pix("wrap0", 0, 127, 0, 8'h90, 0);
      chk_pix("wrap1", 1, 0,   0, 8'h91, 0);
      chk_pix("wrap2", 2, 127, 1, 8'h92, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oled_spi_receiver.md
OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth (at least 2) for every pin input.
REQ-002 SHALL have port clk_ref_in, input, 1, the single system clock.
REQ-003 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-004 SHALL have port oled_csn_in, input, 1, SPI chip select, active low, asynchronous to clk_ref_in.
REQ-005 SHALL have port oled_dc_in, input, 1, data/command select (1=data), asynchronous.
REQ-006 SHALL have port oled_clk_in, input, 1, SPI clock, mode 0, asynchronous.
REQ-007 SHALL have port oled_mosi_in, input, 1, SPI data, MSB first, asynchronous.
REQ-008 SHALL have port byte_valid_out, output, 1, one-cycle pulse marking a received byte.
REQ-009 SHALL have port byte_out, output, 8, last received byte.
REQ-010 SHALL have port byte_dc_out, output, 1, DC value captured with byte_out.
REQ-011 SHALL have port pixel_we_out, output, 1, one-cycle GDDRAM write strobe.
REQ-012 SHALL have port pixel_col_out, output, 7, column of the current write.
REQ-013 SHALL have port pixel_page_out, output, 3, page of the current write.
REQ-014 SHALL have port pixel_data_out, output, 8, data of the current write.
REQ-015 SHALL have port display_on_out, output, 1, display-on state.
REQ-016 SHALL have port frame_done_out, output, 1, one-cycle pulse on full-window pointer wrap.
REQ-017 SHALL have port framing_err_out, output, 1, one-cycle pulse on a truncated byte.

Function
REQ-018 SHALL synchronize csn/dc/clk/mosi through SYNC_STAGES flops; rising oled_clk_in edge = synced clk 0->1 while synced csn=0; clk_ref_in frequency SHALL be at least 4x the SCLK frequency.
REQ-019 SHALL shift synced mosi into an 8-bit register on each detected edge; a 3-bit counter SHALL wrap 7->0.
REQ-020 SHALL, on the 8th edge, latch byte and synced dc and assert byte_valid_out exactly the next cycle.
REQ-021 SHALL clear the bit counter while synced csn=1; synced csn 0->1 with counter!=0 SHALL pulse framing_err_out next cycle and discard the partial byte.
REQ-022 Command FSM states: IDLE, COL_START, COL_END, PAGE_START, PAGE_END, SKIP1; only dc=0 bytes advance it; state persists across csn.
REQ-023 In IDLE: 0x21->COL_START; 0x22->PAGE_START; 0xAE clears display_on_out; 0xAF sets it; 0x20,0x81,0x8D,0xA8,0xD3,0xD5,0xD9,0xDA,0xDB->SKIP1; anything else is ignored.
REQ-024 COL_START/COL_END SHALL load arg[6:0] as col_start/col_end (pointer col<=col_start) and advance; PAGE_START/PAGE_END SHALL do the same with arg[2:0] for pages; SKIP1 SHALL consume one byte->IDLE; COL_END and PAGE_END SHALL ->IDLE.
REQ-025 Each dc=1 byte SHALL pulse pixel_we_out with byte_valid_out, with col/page equal to the pre-increment pointer.
REQ-026 Pointer (horizontal mode): col!=col_end -> col+1; else col<=col_start and page<=(page==page_end ? page_start : page+1).
REQ-027 When col==col_end and page==page_end at a write, frame_done_out SHALL pulse in the same cycle as pixel_we_out.
REQ-028 start>end windows SHALL wrap modulo 128 columns / 8 pages, with no error.

Reset
REQ-029 reset_in SHALL take priority over every concurrent event, including mid-byte.
REQ-030 Reset values: all pulses 0, byte_out 0, byte_dc_out 0, pixel outputs 0, display_on_out 0, FSM IDLE, bit counter 0, window col 0..127 / page 0..7, pointer (0,0).
REQ-031 Synchronizer flops SHALL reset to idle levels: csn 1, clk 0, dc 0, mosi 0.

Structure
REQ-032 Shared package oled_pkg SHALL hold the command opcode constants, FSM state typedef, and column/page width constants.
REQ-033 Sub-module oled_spi_byte_rx SHALL contain sync, edge detection, and the shift/bit counter; the parent SHALL hold the FSM and pointer.

Verification
REQ-034 Send 0xA5 with dc=0 -> one byte_valid_out with byte_out=0xA5, byte_dc_out=0, no pixel_we_out.
REQ-035 Send 0x21,0x02,0x03,0x22,0x06,0x07, then 4 data bytes 0x11..0x14 -> writes at (2,6),(3,6),(2,7),(3,7); frame_done_out on the 4th only.
REQ-036 Send 0xAF then 0xAE -> display_on_out rises after byte 1 and falls after byte 2.
REQ-037 Send 0x81,0xAF -> display_on_out stays 0 (0xAF consumed as argument); a following 0xAF -> 1.
REQ-038 Send 5 bits, then raise csn -> framing_err_out pulses once, no byte_valid_out; the next full byte 0x3C is received correctly.
REQ-039 Assert reset_in after 4 bits of a data byte -> all outputs return to reset values; pointer (0,0).
